// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES I/O loader.
// The loader state enum and the word geometry of key and message.
package aes_io_pkg;

    typedef enum logic [1:0] {
        LOAD,
        REQ,
        DRAIN
    } state_t;

    localparam int KEY_WORDS = 4;
    localparam int MSG_WORDS = 4;
    localparam int WORD_W    = 32;

endpackage

// File: rtl/aes_word_sel.sv
// Combinational 4:1 word mux over a 128-bit vector.
// Index 0 selects the most significant word.
module aes_word_sel
    import aes_io_pkg::*;
(
    input  logic [127:0]      vec,
    input  logic [1:0]        idx,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        unique case (idx)
            2'd0: word = vec[127:96];
            2'd1: word = vec[95:64];
            2'd2: word = vec[63:32];
            2'd3: word = vec[31:0];
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/aes_io_loader.sv
// Loads key and ciphertext word by word, hands them to the AES
// controller, then streams the decrypted message out word by word.
module aes_io_loader #(
    parameter int WAIT_LIMIT = 131072
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         abort,
    input  logic         wr_valid,
    input  logic [31:0]  wr_data,
    output logic         wr_ready,
    output logic [127:0] key,
    output logic [127:0] msg_en,
    output logic         io_ready,
    input  logic         aes_ready,
    input  logic [127:0] msg_de,
    output logic         rd_valid,
    output logic [31:0]  rd_data,
    input  logic         rd_ready,
    output logic         err
);

    import aes_io_pkg::*;

    localparam logic [19:0] LIMIT_M1 = 20'(WAIT_LIMIT - 1);

    state_t       state;
    state_t       state_nx;
    logic [2:0]   wcnt;
    logic [1:0]   dcnt;
    logic [19:0]  timer;
    logic [127:0] cap;
    logic [1:0]   lane;
    logic         wr_fire;
    logic         rd_fire;
    logic         got;
    logic         timeout;

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;
    assign got     = (state == REQ) && aes_ready;
    assign timeout = (state == REQ) && !aes_ready && (timer == LIMIT_M1);
    assign lane    = 2'd3 - wcnt[1:0];

    always_ff @(posedge clk) begin
        if (!reset_n || abort) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD: begin
                if (wr_fire && wcnt == 3'd7) state_nx = REQ;
            end
            REQ: begin
                if (got) state_nx = DRAIN;
                else if (timeout) state_nx = LOAD;
            end
            DRAIN: begin
                if (rd_fire && dcnt == 2'd3) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        io_ready = 1'b0;
        rd_valid = 1'b0;
        unique case (state)
            LOAD:  wr_ready = 1'b1;
            REQ:   io_ready = 1'b1;
            DRAIN: rd_valid = 1'b1;
            default: wr_ready = 1'b0;
        endcase
    end

    // Abort wipes the transaction but deliberately leaves err alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wcnt   <= '0;
            dcnt   <= '0;
            timer  <= '0;
            key    <= '0;
            msg_en <= '0;
            cap    <= '0;
            err    <= 1'b0;
        end else if (abort) begin
            wcnt   <= '0;
            dcnt   <= '0;
            timer  <= '0;
            key    <= '0;
            msg_en <= '0;
            cap    <= '0;
        end else begin
            if (wr_fire) begin
                wcnt <= wcnt + 3'd1;
                if (wcnt[2]) msg_en[{lane, 5'd0} +: 32] <= wr_data;
                else         key[{lane, 5'd0} +: 32]    <= wr_data;
            end
            if (state == REQ && state_nx == REQ) timer <= timer + 20'd1;
            else                                 timer <= '0;
            if (got) begin
                cap  <= msg_de;
                dcnt <= '0;
            end else if (rd_fire) begin
                dcnt <= dcnt + 2'd1;
            end
            if (timeout)                         err <= 1'b1;
            else if (wr_fire && wcnt == 3'd0)    err <= 1'b0;
        end
    end

    aes_word_sel u_sel (
        .vec  (cap),
        .idx  (dcnt),
        .word (rd_data)
    );

endmodule

// File: tb/tb_aes_io_loader.sv
// Directed self-checking bench for aes_io_loader (WAIT_LIMIT=16).
module tb_aes_io_loader;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         abort = 1'b0;
    logic         wr_valid = 1'b0;
    logic [31:0]  wr_data = '0;
    logic         wr_ready;
    logic [127:0] key;
    logic [127:0] msg_en;
    logic         io_ready;
    logic         aes_ready = 1'b0;
    logic [127:0] msg_de = '0;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         rd_ready = 1'b0;
    logic         err;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] KEY_E = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] MSG_E = 128'hDAEC3055DF058E1C39E814EA76F6747E;
    localparam logic [127:0] DE_E  = 128'h0123456789ABCDEF0011223344556677;

    logic [31:0] words [8] = '{32'h00010203, 32'h04050607, 32'h08090A0B,
                               32'h0C0D0E0F, 32'hDAEC3055, 32'hDF058E1C,
                               32'h39E814EA, 32'h76F6747E};
    logic [31:0] exp_rd [4] = '{32'h01234567, 32'h89ABCDEF,
                                32'h00112233, 32'h44556677};

    always #5 clk = ~clk;

    aes_io_loader #(.WAIT_LIMIT(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .key       (key),
        .msg_en    (msg_en),
        .io_ready  (io_ready),
        .aes_ready (aes_ready),
        .msg_de    (msg_de),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = words[i];
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic full_load(input string tag);
        load_words(7);
        chk({tag, "_pre_io"}, io_ready, 1'b0);
        chk({tag, "_pre_wr"}, wr_ready, 1'b1);
        wr_valid = 1'b1;
        wr_data  = words[7];
        tick();
        wr_valid = 1'b0;
        chk({tag, "_io"}, io_ready, 1'b1);
        chk({tag, "_wr"}, wr_ready, 1'b0);
        chk({tag, "_key"}, key, KEY_E);
        chk({tag, "_msg"}, msg_en, MSG_E);
    endtask

    task automatic drain(input string tag, input bit toggle, input int start);
        int k = start;
        int n = 0;
        bit r = 1'b1;
        while (k < 4 && n < 20) begin
            rd_ready = r;
            chk($sformatf("%s_valid%0d", tag, n), rd_valid, 1'b1);
            chk($sformatf("%s_data%0d", tag, n), rd_data, exp_rd[k]);
            tick();
            if (r) k++;
            if (toggle) r = !r;
            n++;
        end
        rd_ready = 1'b0;
        chk({tag, "_count"}, k, 4);
        chk({tag, "_wr"}, wr_ready, 1'b1);
        chk({tag, "_rdv"}, rd_valid, 1'b0);
        chk({tag, "_key"}, key, KEY_E);
    endtask

    task automatic pulse_aes();
        msg_de    = DE_E;
        aes_ready = 1'b1;
        tick();
        aes_ready = 1'b0;
        msg_de    = '0;
        chk("aes_rdv", rd_valid, 1'b1);
        chk("aes_io", io_ready, 1'b0);
    endtask

    initial begin
        int n;
        tick();
        tick();
        chk("rst_wr", wr_ready, 1'b1);
        chk("rst_io", io_ready, 1'b0);
        chk("rst_rdv", rd_valid, 1'b0);
        chk("rst_rdd", rd_data, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_key", key, 128'h0);
        reset_n = 1'b1;
        tick();

        full_load("ld1");
        pulse_aes();
        drain("dr1", 1'b1, 0);

        full_load("ld2");
        n = 0;
        while (io_ready && n < 40) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_err", err, 1'b1);
        chk("to_wr", wr_ready, 1'b1);
        chk("to_key", key, KEY_E);
        load_words(1);
        chk("to_errclr", err, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab1_key", key, 128'h0);

        full_load("ld3");
        for (int i = 0; i < 15; i++) tick();
        chk("late_io", io_ready, 1'b1);
        pulse_aes();
        chk("late_err", err, 1'b0);
        drain("dr3", 1'b0, 0);

        load_words(6);
        abort    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'hFFFFFFFF;
        tick();
        abort    = 1'b0;
        wr_valid = 1'b0;
        chk("ab_key", key, 128'h0);
        chk("ab_msg", msg_en, 128'h0);
        chk("ab_wr", wr_ready, 1'b1);
        chk("ab_rdv", rd_valid, 1'b0);
        full_load("ld4");
        pulse_aes();
        rd_ready = 1'b1;
        tick();
        tick();
        rd_ready = 1'b0;
        chk("mid_rdd", rd_data, exp_rd[2]);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rs_key", key, 128'h0);
        chk("rs_msg", msg_en, 128'h0);
        chk("rs_rdv", rd_valid, 1'b0);
        chk("rs_rdd", rd_data, 32'h0);
        chk("rs_wr", wr_ready, 1'b1);
        full_load("ld5");
        pulse_aes();
        drain("dr5", 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
